// File: rtl/fdce_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fdce_pipe_pkg                                                    |
// | Purpose  : Shared limits and elaboration helpers for the fdce_pipe family.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

package fdce_pipe_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int MAX_DEPTH = 32;

  // Ceiling log2 usable in constant expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fdce_vec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fdce_vec                                                         |
// | Purpose  : WIDTH-bit clock-enabled register, async clear + sync reset.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module fdce_vec #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INIT          = '0,
  parameter logic             IS_C_INVERTED = 1'b0
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             CE,
  input  logic             SR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;

  generate
    if (IS_C_INVERTED) begin : g_neg_edge
      always_ff @(negedge C or negedge CLR_N) begin
        if (!CLR_N)  r_q <= INIT;
        else if (SR) r_q <= INIT;
        else if (CE) r_q <= D;
      end
    end else begin : g_pos_edge
      always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N)  r_q <= INIT;
        else if (SR) r_q <= INIT;
        else if (CE) r_q <= D;
      end
    end
  endgenerate

  assign Q = r_q;

endmodule

`default_nettype wire

// File: rtl/fdce_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fdce_pipe                                                        |
// | Purpose  : WIDTH x DEPTH clock-enabled shift pipeline with dynamic tap     |
// |            and saturating fill counter.                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module fdce_pipe
  import fdce_pipe_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               DEPTH         = 4,
  parameter logic [WIDTH-1:0] INIT          = '0,
  parameter logic             IS_C_INVERTED = 1'b0,
  parameter logic [WIDTH-1:0] IS_D_INVERTED = '0,
  parameter logic             DYNAMIC       = 1'b1,
  localparam int              AW            = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
  localparam int              CW            = clog2(DEPTH + 1)
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             CE,
  input  logic             SR,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_LAST,
  output logic [CW-1:0]    FILL,
  output logic             FULL
);

  localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("fdce_pipe: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("fdce_pipe: DEPTH=%0d outside 1..%0d", DEPTH, MAX_DEPTH);
    end
  endgenerate

  logic [WIDTH-1:0] w_d_in;
  logic [WIDTH-1:0] w_stage   [DEPTH];
  logic [WIDTH-1:0] w_stage_d [DEPTH];

  assign w_d_in = D ^ IS_D_INVERTED;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign w_stage_d[i] = w_d_in;
      end else begin : g_tail
        assign w_stage_d[i] = w_stage[i-1];
      end

      fdce_vec #(
        .WIDTH         (WIDTH),
        .INIT          (INIT),
        .IS_C_INVERTED (IS_C_INVERTED)
      ) u_vec (
        .C     (C),
        .CLR_N (CLR_N),
        .CE    (CE),
        .SR    (SR),
        .D     (w_stage_d[i]),
        .Q     (w_stage[i])
      );
    end
  endgenerate

  assign Q_LAST = w_stage[DEPTH-1];

  // FILL and FULL share one register so both clear, reset and advance with the stages.
  logic [CW-1:0] w_fill_next;
  logic          w_full_next;
  logic [CW:0]   w_cnt_q;

  assign w_fill_next = FULL ? FILL : FILL + CW'(1);
  assign w_full_next = (w_fill_next == c_depth);

  fdce_vec #(
    .WIDTH         (CW + 1),
    .INIT          ({(CW + 1){1'b0}}),
    .IS_C_INVERTED (IS_C_INVERTED)
  ) u_fill (
    .C     (C),
    .CLR_N (CLR_N),
    .CE    (CE),
    .SR    (SR),
    .D     ({w_full_next, w_fill_next}),
    .Q     (w_cnt_q)
  );

  assign FILL = w_cnt_q[CW-1:0];
  assign FULL = w_cnt_q[CW];

  generate
    if (DYNAMIC) begin : g_dynamic
      logic [AW-1:0]    w_idx;
      logic [WIDTH-1:0] w_tap;

      // Addresses past the last stage clamp to it, so an unused code never reads X.
      assign w_idx = (A > c_last_idx) ? c_last_idx : A;

      always_comb begin
        w_tap = w_stage[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
          if (w_idx == AW'(i)) w_tap = w_stage[i];
        end
      end

      assign Q = w_tap;
    end else begin : g_static
      logic [AW-1:0] w_unused_a;
      assign w_unused_a = A;
      assign Q          = Q_LAST;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fdce_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fdce_pipe                                                     |
// | Purpose  : Self-checking bench for fdce_pipe across four parameter builds.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module tb_fdce_pipe;

  localparam int NDUT = 4;

  logic       C     = 1'b0;
  logic       CLR_N = 1'b1;
  logic       CE    = 1'b0;
  logic       SR    = 1'b0;
  logic [7:0] D     = '0;
  logic [1:0] a0    = '0;
  logic [2:0] a1    = '0;
  logic [0:0] a2    = '0;
  logic [1:0] a3    = '0;

  logic [7:0] q0, ql0, q1, ql1, q2, ql2, q3, ql3;
  logic [2:0] fill0, fill1, fill3;
  logic [0:0] fill2;
  logic       full0, full1, full2, full3;

  int checks   = 0;
  int failures = 0;

  // Reference: per build, a history of values shifted in (index 0 newest) and a fill count.
  int         m_depth [NDUT] = '{4, 6, 1, 4};
  logic [7:0] m_init  [NDUT] = '{8'hA5, 8'h3C, 8'h5A, 8'h00};
  logic [7:0] m_mask  [NDUT] = '{8'h00, 8'h0F, 8'h00, 8'h00};
  logic [7:0] m_stage [NDUT][32];
  int         m_fill  [NDUT];

  logic [7:0] exp_ql   [5] = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02};
  int         exp_fill [5] = '{1, 2, 3, 4, 4};

  fdce_pipe #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5)) u_dut0 (
    .C(C), .CLR_N(CLR_N), .CE(CE), .SR(SR), .D(D), .A(a0),
    .Q(q0), .Q_LAST(ql0), .FILL(fill0), .FULL(full0));

  fdce_pipe #(.WIDTH(8), .DEPTH(6), .INIT(8'h3C), .IS_D_INVERTED(8'h0F)) u_dut1 (
    .C(C), .CLR_N(CLR_N), .CE(CE), .SR(SR), .D(D), .A(a1),
    .Q(q1), .Q_LAST(ql1), .FILL(fill1), .FULL(full1));

  fdce_pipe #(.WIDTH(8), .DEPTH(1), .INIT(8'h5A)) u_dut2 (
    .C(C), .CLR_N(CLR_N), .CE(CE), .SR(SR), .D(D), .A(a2),
    .Q(q2), .Q_LAST(ql2), .FILL(fill2), .FULL(full2));

  fdce_pipe #(.WIDTH(8), .DEPTH(4), .INIT(8'h00), .IS_C_INVERTED(1'b1), .DYNAMIC(1'b0)) u_dut3 (
    .C(C), .CLR_N(CLR_N), .CE(CE), .SR(SR), .D(D), .A(a3),
    .Q(q3), .Q_LAST(ql3), .FILL(fill3), .FULL(full3));

  always #10 C = ~C;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_clear(input int k);
    for (int j = 0; j < 32; j++) m_stage[k][j] = m_init[k];
    m_fill[k] = 0;
  endtask

  task automatic m_clear_all();
    for (int k = 0; k < NDUT; k++) m_clear(k);
  endtask

  task automatic m_edge(input int k);
    if (!CLR_N || SR) begin
      m_clear(k);
    end else if (CE) begin
      for (int j = 31; j > 0; j--) m_stage[k][j] = m_stage[k][j-1];
      m_stage[k][0] = D ^ m_mask[k];
      if (m_fill[k] < m_depth[k]) m_fill[k] = m_fill[k] + 1;
    end
  endtask

  function automatic logic [7:0] m_tap(input int k, input int a);
    int idx;
    idx = (a >= m_depth[k]) ? m_depth[k] - 1 : a;
    return m_stage[k][idx];
  endfunction

  function automatic logic [7:0] m_last(input int k);
    return m_stage[k][m_depth[k] - 1];
  endfunction

  always @(posedge C) begin
    m_edge(0);
    m_edge(1);
    m_edge(2);
  end

  always @(negedge C) m_edge(3);

  task automatic check_all(input string ph);
    check({ph, " q0"},    32'(q0),    32'(m_tap(0, int'(a0))));
    check({ph, " ql0"},   32'(ql0),   32'(m_last(0)));
    check({ph, " fill0"}, 32'(fill0), 32'(m_fill[0]));
    check({ph, " full0"}, 32'(full0), 32'(m_fill[0] == m_depth[0]));
    check({ph, " q1"},    32'(q1),    32'(m_tap(1, int'(a1))));
    check({ph, " ql1"},   32'(ql1),   32'(m_last(1)));
    check({ph, " fill1"}, 32'(fill1), 32'(m_fill[1]));
    check({ph, " full1"}, 32'(full1), 32'(m_fill[1] == m_depth[1]));
    check({ph, " q2"},    32'(q2),    32'(m_tap(2, int'(a2))));
    check({ph, " ql2"},   32'(ql2),   32'(m_last(2)));
    check({ph, " fill2"}, 32'(fill2), 32'(m_fill[2]));
    check({ph, " full2"}, 32'(full2), 32'(m_fill[2] == m_depth[2]));
    check({ph, " q3"},    32'(q3),    32'(m_last(3)));
    check({ph, " ql3"},   32'(ql3),   32'(m_last(3)));
    check({ph, " fill3"}, 32'(fill3), 32'(m_fill[3]));
    check({ph, " full3"}, 32'(full3), 32'(m_fill[3] == m_depth[3]));
  endtask

  initial begin
    m_clear_all();

    // Clear asserted before any clock edge.
    #1 CLR_N = 1'b0;
    m_clear_all();
    #1;
    check("rst ql0", 32'(ql0), 32'h0000_00A5);
    check("rst fill0", 32'(fill0), 32'd0);
    check("rst full0", 32'(full0), 32'd0);
    check_all("rst");
    #1 CLR_N = 1'b1;
    CE = 1'b1;
    D  = 8'h01;

    // Stream 1..5; falling-edge build lags by one half period.
    for (int k = 1; k <= 5; k++) begin
      @(posedge C); #1;
      check("stream ql0", 32'(ql0), 32'(exp_ql[k-1]));
      check("stream fill0", 32'(fill0), 32'(exp_fill[k-1]));
      check("stream full0", 32'(full0), 32'(k >= 4));
      check("stream q2", 32'(q2), 32'(k));
      check("stream full2", 32'(full2), 32'd1);
      check("stream fill3", 32'(fill3), 32'(k - 1));
      check_all("stream");
      D = 8'(k + 1);
      if (k == 4) begin
        for (int a = 0; a < 4; a++) begin
          a0 = 2'(a); #1;
          check("tap after 4", 32'(q0), 32'(4 - a));
        end
      end
    end

    // Disabled edges freeze all state.
    CE = 1'b0;
    for (int n = 0; n < 3; n++) begin
      D = 8'($urandom);
      @(posedge C); #1;
      check("hold ql0", 32'(ql0), 32'h0000_0002);
      check("hold fill0", 32'(fill0), 32'd4);
      check_all("hold");
    end
    for (int a = 0; a < 4; a++) begin
      a0 = 2'(a); #1;
      check("hold tap", 32'(q0), 32'(5 - a));
    end

    // Sixth enabled edge fills the DEPTH=6 build; check clamp of A.
    CE = 1'b1;
    D  = 8'h06;
    @(posedge C); #1;
    check_all("fill6");
    check("fill6 full1", 32'(full1), 32'd1);
    a1 = 3'd5; #1;
    check("clamp a5", 32'(q1), 32'h0000_000E);
    a1 = 3'd7; #1;
    check("clamp a7", 32'(q1), 32'h0000_000E);
    a1 = 3'd0; #1;
    check("tap a0 d1", 32'(q1), 32'h0000_0009);

    // SR beats CE.
    SR = 1'b1;
    D  = 8'hFF;
    @(posedge C); #1;
    check("sr ql0", 32'(ql0), 32'h0000_00A5);
    check("sr fill0", 32'(fill0), 32'd0);
    check("sr full0", 32'(full0), 32'd0);
    check("sr ql1", 32'(ql1), 32'h0000_003C);
    check("sr q2", 32'(q2), 32'h0000_005A);
    check_all("sr");
    for (int a = 0; a < 4; a++) begin
      a0 = 2'(a); #1;
      check("sr tap", 32'(q0), 32'h0000_00A5);
    end
    SR = 1'b0;
    D  = 8'h00;

    // D inversion mask: zeros in, 0x0F out after six edges.
    for (int n = 0; n < 6; n++) begin
      @(posedge C); #1;
      check_all("dinv");
    end
    check("dinv ql1", 32'(ql1), 32'h0000_000F);

    // Clear between edges acts immediately.
    CLR_N = 1'b0;
    m_clear_all();
    #1;
    check("aclr ql0", 32'(ql0), 32'h0000_00A5);
    check("aclr fill1", 32'(fill1), 32'd0);
    check_all("aclr");
    @(posedge C); #1;
    check_all("aclr held");
    CLR_N = 1'b1;

    // Randomised traffic against the reference.
    for (int n = 0; n < 400; n++) begin
      @(posedge C); #1;
      check_all("rand pos");
      CE = ($urandom_range(3) != 0);
      SR = ($urandom_range(19) == 0);
      D  = 8'($urandom);
      a0 = 2'($urandom);
      a1 = 3'($urandom);
      a2 = 1'($urandom);
      a3 = 2'($urandom);
      if (!CLR_N) begin
        CLR_N = 1'b1;
      end else if ($urandom_range(31) == 0) begin
        CLR_N = 1'b0;
        m_clear_all();
      end
      #1;
      check_all("rand in");
      @(negedge C); #1;
      check_all("rand neg");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
